// File: rtl/clk_rate_detector.sv
// Recovers the 2-bit rate code of a slow divided clock by timing its period against clk.
// Optional feature: define FREQ_LOCK_EN to require LOCK_COUNT matching classifications before code/valid update.
module clk_rate_detector #(
  parameter int BASE_LOG2  = 22,
  parameter int CNT_W      = BASE_LOG2 + 5,
  parameter int LOCK_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_clk,
  output logic [1:0] code,
  output logic       valid,
  output logic       err,
  output logic       no_sig,
  output logic       meas_done
);

  typedef enum logic {S_IDLE, S_MEASURE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(1) << (BASE_LOG2 + 4);
  localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(3) << (BASE_LOG2 - 2);
  localparam logic [CNT_W-1:0] WIN_HI0 = CNT_W'(3) << (BASE_LOG2 - 1);
  localparam logic [CNT_W-1:0] WIN_HI1 = CNT_W'(3) << BASE_LOG2;
  localparam logic [CNT_W-1:0] WIN_HI2 = CNT_W'(3) << (BASE_LOG2 + 1);
  localparam logic [CNT_W-1:0] WIN_HI3 = CNT_W'(3) << (BASE_LOG2 + 2);

  state_t           r_state;
  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_idle;
  logic [1:0]       r_code;
  logic             r_valid, r_err, r_no_sig, r_meas_done;

  logic             w_rise;
  logic             w_in_range;
  logic [1:0]       w_class;

  assign w_rise     = r_s2 & ~r_s3;
  // Windows are contiguous, so one lower and one upper bound decide range membership.
  assign w_in_range = (r_cnt > WIN_LO) && (r_cnt <= WIN_HI3);
  assign w_class    = (r_cnt <= WIN_HI0) ? 2'b11 :
                      (r_cnt <= WIN_HI1) ? 2'b10 :
                      (r_cnt <= WIN_HI2) ? 2'b01 : 2'b00;

`ifdef FREQ_LOCK_EN
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);

  logic [MW-1:0] r_match;
  logic [1:0]    r_last;
  logic [MW-1:0] w_match_nxt;

  assign w_match_nxt = (r_match != '0 && w_class == r_last)
                       ? ((r_match >= LOCK_N) ? r_match : r_match + MW'(1))
                       : MW'(1);
`endif

  // NOTE: all state is registered with non-blocking assignments so every flop
  // samples pre-edge values; reset is synchronous, checked first in the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_cnt       <= '0;
      r_idle      <= '0;
      r_code      <= 2'b00;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_no_sig    <= 1'b0;
      r_meas_done <= 1'b0;
`ifdef FREQ_LOCK_EN
      r_match     <= '0;
      r_last      <= 2'b00;
`endif
    end else begin
      r_s1        <= in_clk;
      r_s2        <= r_s1;
      r_s3        <= r_s2;
      r_meas_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            // First edge after idle only arms the period counter.
            r_state  <= S_MEASURE;
            r_cnt    <= CNT_W'(1);
            r_idle   <= '0;
            r_no_sig <= 1'b0;
          end else if (r_idle == TIMEOUT) begin
            r_no_sig <= 1'b1;
            r_valid  <= 1'b0;
            r_idle   <= '0;
`ifdef FREQ_LOCK_EN
            r_match  <= '0;
`endif
          end else begin
            r_idle <= r_idle + CNT_W'(1);
          end
        end
        S_MEASURE: begin
          if (w_rise) begin
            r_cnt       <= CNT_W'(1);
            r_meas_done <= 1'b1;
            if (w_in_range) begin
              r_err <= 1'b0;
`ifdef FREQ_LOCK_EN
              r_match <= w_match_nxt;
              r_last  <= w_class;
              if (w_match_nxt >= LOCK_N) begin
                r_code  <= w_class;
                r_valid <= 1'b1;
              end
`else
              r_code  <= w_class;
              r_valid <= 1'b1;
`endif
            end else begin
              r_err   <= 1'b1;
              r_valid <= 1'b0;
`ifdef FREQ_LOCK_EN
              r_match <= '0;
`endif
            end
          end else if (r_cnt == TIMEOUT) begin
            // Timeout stops the counter before it can wrap.
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_no_sig <= 1'b1;
            r_valid  <= 1'b0;
`ifdef FREQ_LOCK_EN
            r_match  <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign code      = r_code;
  assign valid     = r_valid;
  assign err       = r_err;
  assign no_sig    = r_no_sig;
  assign meas_done = r_meas_done;

endmodule
